// File: rtl/hybrid_adder_seq_pkg.sv
// Shared constants and state encoding for the byte-serial hybrid adder sequencer.
package hybrid_adder_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hybrid_adder_seq_if.sv
// Request/response bundle between a requester and the hybrid adder sequencer.
// HYBRID_ADDER_SEQ_SUB_EN adds the sub request bit.
interface hybrid_adder_seq_if #(
  parameter int unsigned NSLICE = 4
);
  import hybrid_adder_seq_pkg::*;

  localparam int unsigned W = SLICE_W * NSLICE;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef HYBRID_ADDER_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;

  modport master (
`ifdef HYBRID_ADDER_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, op_a, op_b, cin, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
`ifdef HYBRID_ADDER_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, cin, out_ready,
    output in_ready, out_valid, result, cout
  );

endinterface

// File: rtl/hybrid_adder.sv
// Combinational 8-bit hybrid adder: ripple low nibble, carry-select high nibble.
module hybrid_adder
  import hybrid_adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] sum,
  output logic               co
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Both high-nibble candidates are formed up front; the low-nibble carry picks one.
  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum = lo[4] ? {hi1[3:0], lo[3:0]} : {hi0[3:0], lo[3:0]};
    co  = lo[4] ? hi1[4] : hi0[4];
  end

endmodule

// File: rtl/hybrid_adder_seq.sv
// Byte-serial W-bit adder reusing one 8-bit hybrid_adder, LSB slice first.
// Optional subtract mode under HYBRID_ADDER_SEQ_SUB_EN.
module hybrid_adder_seq
  import hybrid_adder_seq_pkg::*;
#(
  parameter int unsigned NSLICE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hybrid_adder_seq_if.slave bus
);

  localparam int unsigned W     = SLICE_W * NSLICE;
  localparam int unsigned IDX_W = $clog2(NSLICE) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SLICE_W-1:0] sum;
  logic               cy_out;
  logic [W+SLICE_W-1:0] res_cat;
  logic [W-1:0]       op_b_eff;
  logic               cin_eff;

  // Subtraction is a + ~b + 1, folded into the operand load.
`ifdef HYBRID_ADDER_SEQ_SUB_EN
  assign op_b_eff = bus.sub ? ~bus.op_b : bus.op_b;
  assign cin_eff  = bus.sub ? 1'b1 : bus.cin;
`else
  assign op_b_eff = bus.op_b;
  assign cin_eff  = bus.cin;
`endif

  hybrid_adder u_slice (
    .a   (a_q[SLICE_W-1:0]),
    .b   (b_q[SLICE_W-1:0]),
    .ci  (carry_q),
    .sum (sum),
    .co  (cy_out)
  );

  // Next-state and datapath updates; everything holds unless the state acts on it.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    res_cat  = {sum, result_q};
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = op_b_eff;
          carry_d = cin_eff;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // New slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0.
        result_d = res_cat[W+SLICE_W-1:SLICE_W];
        a_d      = a_q >> SLICE_W;
        b_d      = b_q >> SLICE_W;
        carry_d  = cy_out;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          cout_d  = cy_out;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_hybrid_adder_seq.sv
// Directed bench for hybrid_adder_seq with NSLICE=4.
module tb_hybrid_adder_seq;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] held;

  hybrid_adder_seq_if #(.NSLICE(4)) bus ();

  hybrid_adder_seq #(.NSLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef HYBRID_ADDER_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xD + 0x91 + 1, exact latency
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h0000000D;
    bus.op_b     = 32'h00000091;
    bus.cin      = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = 32'hDEADBEEF;
    bus.cin      = 1'b0;
    chk("t1_in_ready_run", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_out_valid_early", 64'(bus.out_valid), 64'd0);
      if (i < 3) @(negedge clk);
    end
    @(negedge clk);
    chk("t1_out_valid_lat4", 64'(bus.out_valid), 64'd1);
    chk("t1_result", 64'(bus.result), 64'h0000009F);
    chk("t1_cout", 64'(bus.cout), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t1_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t1_idle_out_valid", 64'(bus.out_valid), 64'd0);

    // Full carry ripple
    bus.in_valid = 1'b1;
    bus.op_a     = 32'hFFFFFFFF;
    bus.op_b     = 32'h00000001;
    bus.cin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("t2_done");
    chk("t2_result", 64'(bus.result), 64'h00000000);
    chk("t2_cout", 64'(bus.cout), 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Stall in DONE for 5 cycles
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h12345678;
    bus.op_b     = 32'h9ABCDEF0;
    bus.cin      = 1'b0;
    @(negedge clk);
    wait_done("t3_done");
    held = 32'hACF13568;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t3_hold_result", 64'(bus.result), 64'(held));
      chk("t3_hold_cout", 64'(bus.cout), 64'd0);
      chk("t3_hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t3_back_idle", 64'(bus.in_ready), 64'd1);

    // Reset during the second RUN cycle
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h11111111;
    bus.op_b     = 32'h22222222;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_rst_result", 64'(bus.result), 64'd0);
    chk("t4_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t4_rst_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h00000001;
    bus.op_b     = 32'h00000001;
    bus.cin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("t4_done");
    chk("t4_result", 64'(bus.result), 64'h00000002);
    chk("t4_cout", 64'(bus.cout), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back with in_valid held and out_ready high
    bus.in_valid = 1'b1;
    bus.op_a     = 32'h0000FFFF;
    bus.op_b     = 32'h00000001;
    @(negedge clk);
    bus.op_a     = 32'h80000000;
    bus.op_b     = 32'h80000000;
    wait_done("t5a_done");
    chk("t5a_result", 64'(bus.result), 64'h00010000);
    chk("t5a_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    chk("t5_gap_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t5_gap_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t5b_accepted", 64'(bus.in_ready), 64'd0);
    wait_done("t5b_done");
    chk("t5b_result", 64'(bus.result), 64'h00000000);
    chk("t5b_cout", 64'(bus.cout), 64'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;

`ifdef HYBRID_ADDER_SEQ_SUB_EN
    // Subtraction: 5-7 borrows, 7-5 does not
    bus.in_valid = 1'b1;
    bus.sub      = 1'b1;
    bus.cin      = 1'b0;
    bus.op_a     = 32'd5;
    bus.op_b     = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done("t6a_done");
    chk("t6a_result", 64'(bus.result), 64'hFFFFFFFE);
    chk("t6a_cout", 64'(bus.cout), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sub      = 1'b0;
    wait_done("t6b_done");
    chk("t6b_result", 64'(bus.result), 64'h00000002);
    chk("t6b_cout", 64'(bus.cout), 64'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
